scarv_cop_issue_ctrl: RTL and testbench

Issue/sequencing controller between the host core's coprocessor interface and the ISE functional units. Latches one encoded instruction, drives it to the combinational ISE decoder, dispatches it to exactly one functional unit selected by the decoded one-hot class, waits for completion, then returns a status/writeback response to the core. One instruction in flight at a time; multi-cycle FUs are handled by a valid/done handshake.

---
 rtl/scarv_cop_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_scarv_cop_issue_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_issue_ctrl.sv
// scarv_cop_issue_ctrl: single-issue sequencer between the core's
// coprocessor interface and the ISE functional units.
// Flow: IDLE -> DISPATCH -> EXEC -> RESP -> IDLE.
// A decode error skips EXEC and goes straight from DISPATCH to RESP.
// Optional FU watchdog: define SCARV_COP_ISSUE_TIMEOUT_EN.
module scarv_cop_issue_ctrl #(
  parameter int NCLASS         = 9,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              cpi_insn_valid,
  output logic              cpi_insn_ready,
  input  logic [31:0]       cpi_insn,
  output logic              cpi_rsp_valid,
  input  logic              cpi_rsp_ready,
  output logic [2:0]        cpi_rsp_status,
  output logic              cpi_rsp_wen,
  output logic [4:0]        cpi_rsp_rd,
  output logic [31:0]       cpi_rsp_data,
  output logic [31:0]       id_encoded,
  input  logic              id_exception,
  input  logic [NCLASS-1:0] id_class,
  input  logic [4:0]        id_rd,
  input  logic              gpr_write,
  output logic [NCLASS-1:0] fu_ivalid,
  input  logic [NCLASS-1:0] fu_idone,
  input  logic [31:0]       fu_rdata,
  output logic              busy
);

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  typedef enum logic [1:0] {IDLE, DISPATCH, EXEC, RESP} state_t;

  localparam logic [2:0] ST_OK  = 3'd0;
  localparam logic [2:0] ST_DEC = 3'd1;
`ifdef SCARV_COP_ISSUE_TIMEOUT_EN
  localparam logic [2:0] ST_TO  = 3'd2;
  // The last EXEC cycle before expiry is the one where the counter holds limit-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;
`endif

  state_t            state;
  logic [31:0]       r_insn;
  logic [NCLASS-1:0] r_class;
  logic [4:0]        r_rd;
  logic              r_gpr_write;
  logic              class_bad;
  logic              done_hit;

  // Zero or more than one class bit means the decoder could not pick a unit.
  assign class_bad = (id_class == '0) || ((id_class & (id_class - NCLASS'(1))) != '0);
  // Only the completion bit of the unit that was dispatched is honoured.
  assign done_hit  = |(fu_idone & r_class);

  assign id_encoded     = r_insn;
  assign cpi_insn_ready = (state == IDLE);
  assign busy           = (state != IDLE);
  // Derived from state so the request falls with the async reset.
  assign fu_ivalid      = (state == EXEC) ? r_class : '0;

  // Main sequencing FSM with registered response fields.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state          <= IDLE;
      r_insn         <= '0;
      r_class        <= '0;
      r_rd           <= '0;
      r_gpr_write    <= 1'b0;
      cpi_rsp_valid  <= 1'b0;
      cpi_rsp_status <= ST_OK;
      cpi_rsp_wen    <= 1'b0;
      cpi_rsp_rd     <= '0;
      cpi_rsp_data   <= '0;
`ifdef SCARV_COP_ISSUE_TIMEOUT_EN
      to_cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cpi_insn_valid) begin
            r_insn <= cpi_insn;
            state  <= DISPATCH;
          end
        end
        DISPATCH: begin
          r_class     <= id_class;
          r_rd        <= id_rd;
          r_gpr_write <= gpr_write;
`ifdef SCARV_COP_ISSUE_TIMEOUT_EN
          to_cnt      <= '0;
`endif
          if (id_exception || class_bad) begin
            cpi_rsp_status <= ST_DEC;
            cpi_rsp_wen    <= 1'b0;
            cpi_rsp_rd     <= id_rd;
            cpi_rsp_data   <= '0;
            cpi_rsp_valid  <= 1'b1;
            state          <= RESP;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          // A done arriving on the final watchdog cycle still wins.
          if (done_hit) begin
            cpi_rsp_status <= ST_OK;
            cpi_rsp_wen    <= r_gpr_write;
            cpi_rsp_rd     <= r_rd;
            cpi_rsp_data   <= fu_rdata;
            cpi_rsp_valid  <= 1'b1;
            state          <= RESP;
          end
`ifdef SCARV_COP_ISSUE_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            cpi_rsp_status <= ST_TO;
            cpi_rsp_wen    <= 1'b0;
            cpi_rsp_rd     <= r_rd;
            cpi_rsp_data   <= '0;
            cpi_rsp_valid  <= 1'b1;
            state          <= RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          if (cpi_rsp_ready) begin
            cpi_rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scarv_cop_issue_ctrl.sv
// Testbench for scarv_cop_issue_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_scarv_cop_issue_ctrl;
  localparam int NC = 9;
  localparam int TO = 16;
`ifdef SCARV_COP_ISSUE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic g_clk = 1'b0, g_resetn = 1'b0;
  logic cpi_insn_valid = 1'b0, cpi_insn_ready, cpi_rsp_valid, cpi_rsp_ready = 1'b0;
  logic [31:0] cpi_insn = '0, cpi_rsp_data, id_encoded, fu_rdata = '0;
  logic [2:0] cpi_rsp_status;
  logic cpi_rsp_wen, id_exception = 1'b0, gpr_write = 1'b0, busy;
  logic [4:0] cpi_rsp_rd, id_rd = '0;
  logic [NC-1:0] id_class = '0, fu_ivalid, fu_idone = '0;

  always #5 g_clk = ~g_clk;

  scarv_cop_issue_ctrl #(.NCLASS(NC), .TIMEOUT_CYCLES(TO)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .cpi_insn_valid(cpi_insn_valid), .cpi_insn_ready(cpi_insn_ready), .cpi_insn(cpi_insn),
    .cpi_rsp_valid(cpi_rsp_valid), .cpi_rsp_ready(cpi_rsp_ready), .cpi_rsp_status(cpi_rsp_status),
    .cpi_rsp_wen(cpi_rsp_wen), .cpi_rsp_rd(cpi_rsp_rd), .cpi_rsp_data(cpi_rsp_data),
    .id_encoded(id_encoded), .id_exception(id_exception), .id_class(id_class), .id_rd(id_rd),
    .gpr_write(gpr_write), .fu_ivalid(fu_ivalid), .fu_idone(fu_idone), .fu_rdata(fu_rdata),
    .busy(busy));

  int checks = 0, errors = 0;

  // Observations of the last transaction.
  int o_lat, o_ivc;
  logic o_ivbad, o_unstable, o_rdy_busy, o_end_rdy, o_vld_after, o_hung, o_acc_rdy;
  logic [2:0] o_st;
  logic o_wen;
  logic [4:0] o_rd;
  logic [31:0] o_data, o_enc;

  // Expectations of the last transaction.
  int e_lat, e_ivc;
  logic [2:0] e_st;
  logic e_wen;
  logic [31:0] e_data;

  // Reference model: outcome of one instruction from its decode and FU behaviour.
  // lat is the EXEC cycle (1-based) in which the matching done arrives; 0 = never.
  task automatic model(input logic [NC-1:0] cls, input logic exc, input logic gw,
                       input int lat, input logic [31:0] rdata);
    if (exc || $countones(cls) != 1) begin
      e_lat = 2; e_ivc = 0; e_st = 3'd1; e_wen = 1'b0; e_data = '0;
    end else if (TO_EN && (lat == 0 || lat > TO)) begin
      e_lat = 2 + TO; e_ivc = TO; e_st = 3'd2; e_wen = 1'b0; e_data = '0;
    end else begin
      e_lat = 2 + lat; e_ivc = lat; e_st = 3'd0; e_wen = gw; e_data = rdata;
    end
  endtask

  // Drive one instruction through the core and FU sides, recording what is seen.
  task automatic drive_txn(input logic [31:0] insn, input logic [NC-1:0] cls, input logic exc,
                           input logic gw, input logic [4:0] rd, input int lat,
                           input logic [NC-1:0] wmask, input logic [31:0] rdata, input int rdelay);
    int c, ex, hold;
    logic seen, given;
    @(negedge g_clk);
    o_acc_rdy = cpi_insn_ready;
    cpi_insn_valid = 1'b1; cpi_insn = insn; id_class = cls; id_exception = exc;
    gpr_write = gw; id_rd = rd;
    c = 0; ex = 0; hold = 0; seen = 1'b0; given = 1'b0;
    o_lat = -1; o_ivc = 0; o_ivbad = 1'b0; o_unstable = 1'b0; o_rdy_busy = 1'b0;
    o_end_rdy = 1'b0; o_vld_after = 1'b0; o_hung = 1'b0; o_enc = '0;
    o_st = '0; o_wen = 1'b0; o_rd = '0; o_data = '0;
    forever begin
      @(negedge g_clk);
      c++;
      cpi_insn_valid = 1'b0; fu_idone = '0; cpi_rsp_ready = 1'b0; fu_rdata = $urandom;
      if (given) begin
        o_vld_after = cpi_rsp_valid; o_end_rdy = cpi_insn_ready;
        break;
      end
      if (c == 1) o_enc = id_encoded;
      if (cpi_insn_ready) o_rdy_busy = 1'b1;
      if (fu_ivalid != '0) begin
        ex++; o_ivc++;
        if (fu_ivalid !== cls) o_ivbad = 1'b1;
        if (ex == lat) begin fu_idone = cls; fu_rdata = rdata; end
        else fu_idone = wmask;
      end
      if (cpi_rsp_valid) begin
        if (!seen) begin
          seen = 1'b1; o_lat = c;
          o_st = cpi_rsp_status; o_wen = cpi_rsp_wen; o_rd = cpi_rsp_rd; o_data = cpi_rsp_data;
        end else if ({o_st, o_wen, o_rd, o_data} !== {cpi_rsp_status, cpi_rsp_wen, cpi_rsp_rd, cpi_rsp_data})
          o_unstable = 1'b1;
        if (hold == rdelay) begin cpi_rsp_ready = 1'b1; given = 1'b1; end
        hold++;
      end
      if (c > 300) begin o_hung = 1'b1; break; end
    end
    cpi_rsp_ready = 1'b0; fu_idone = '0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({cpi_rsp_valid, cpi_rsp_status, cpi_rsp_wen, cpi_rsp_rd, cpi_rsp_data} !== '0) begin
      errors++; $display("FAIL reset_rsp got v=%0b st=%0d wen=%0b rd=%0d data=%h exp all 0",
                         cpi_rsp_valid, cpi_rsp_status, cpi_rsp_wen, cpi_rsp_rd, cpi_rsp_data);
    end
    checks++;
    if ({fu_ivalid, busy, id_encoded} !== '0) begin
      errors++; $display("FAIL reset_ctl got ivalid=%b busy=%0b enc=%h exp 0", fu_ivalid, busy, id_encoded);
    end
    repeat (2) @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);
    checks++;
    if (cpi_insn_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle got ready=%0b busy=%0b exp 1 0", cpi_insn_ready, busy);
    end
  endtask

  task automatic test_single_cycle();
    drive_txn(32'h0, 9'b000000100, 1'b0, 1'b1, 5'd5, 1, '0, 32'hDEADBEEF, 0);
    model(9'b000000100, 1'b0, 1'b1, 1, 32'hDEADBEEF);
    checks++;
    if (o_lat !== 3 || o_lat !== e_lat) begin errors++; $display("FAIL single_lat got %0d exp 3", o_lat); end
    checks++;
    if ({o_st, o_wen, o_rd, o_data} !== {3'd0, 1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_rsp got st=%0d wen=%0b rd=%0d data=%h exp 0 1 5 deadbeef", o_st, o_wen, o_rd, o_data);
    end
    checks++;
    if (o_ivc !== 1 || o_ivbad !== 1'b0) begin errors++; $display("FAIL single_ivalid got cycles=%0d bad=%0b exp 1 0", o_ivc, o_ivbad); end
    checks++;
    if (o_vld_after !== 1'b0 || o_end_rdy !== 1'b1) begin
      errors++; $display("FAIL single_release got vld=%0b ready=%0b exp 0 1", o_vld_after, o_end_rdy);
    end
  endtask

  task automatic test_multicycle_backpressure();
    drive_txn(32'h1234_5678, 9'b010000000, 1'b0, 1'b1, 5'd17, 10, '0, 32'hCAFE_F00D, 4);
    checks++;
    if (o_ivc !== 10 || o_ivbad !== 1'b0) begin errors++; $display("FAIL multi_ivalid got cycles=%0d bad=%0b exp 10 0", o_ivc, o_ivbad); end
    checks++;
    if (o_lat !== 12) begin errors++; $display("FAIL multi_lat got %0d exp 12", o_lat); end
    checks++;
    if (o_unstable !== 1'b0) begin errors++; $display("FAIL multi_stable got unstable=%0b exp 0", o_unstable); end
    checks++;
    if (o_rdy_busy !== 1'b0) begin errors++; $display("FAIL multi_ready got ready-high-while-busy=%0b exp 0", o_rdy_busy); end
    checks++;
    if ({o_st, o_wen, o_rd, o_data} !== {3'd0, 1'b1, 5'd17, 32'hCAFEF00D}) begin
      errors++; $display("FAIL multi_rsp got st=%0d wen=%0b rd=%0d data=%h", o_st, o_wen, o_rd, o_data);
    end
    checks++;
    if (o_enc !== 32'h1234_5678) begin errors++; $display("FAIL multi_enc got %h exp 12345678", o_enc); end
  endtask

  task automatic test_decode_error();
    drive_txn(32'hFFFF_0000, 9'b000000011, 1'b1, 1'b1, 5'd9, 1, '0, 32'h1111_1111, 1);
    checks++;
    if (o_lat !== 2) begin errors++; $display("FAIL decerr_lat got %0d exp 2", o_lat); end
    checks++;
    if ({o_st, o_wen, o_data} !== {3'd1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL decerr_rsp got st=%0d wen=%0b data=%h exp 1 0 0", o_st, o_wen, o_data);
    end
    checks++;
    if (o_ivc !== 0) begin errors++; $display("FAIL decerr_ivalid got %0d cycles exp 0", o_ivc); end
    // Zero class without an exception flag is also a decode error.
    drive_txn(32'h0000_0042, 9'b000000000, 1'b0, 1'b1, 5'd3, 1, '0, 32'h2222_2222, 0);
    checks++;
    if (o_lat !== 2 || o_st !== 3'd1 || o_wen !== 1'b0) begin
      errors++; $display("FAIL decerr_zero got lat=%0d st=%0d wen=%0b exp 2 1 0", o_lat, o_st, o_wen);
    end
  endtask

  task automatic test_wrong_done();
    drive_txn(32'hA5A5_A5A5, 9'b000001000, 1'b0, 1'b0, 5'd2, 6, 9'b000100000, 32'h0BAD_C0DE, 0);
    checks++;
    if (o_ivc !== 6 || o_lat !== 8) begin errors++; $display("FAIL wrongdone got cycles=%0d lat=%0d exp 6 8", o_ivc, o_lat); end
    checks++;
    if ({o_st, o_wen, o_data} !== {3'd0, 1'b0, 32'h0BADC0DE}) begin
      errors++; $display("FAIL wrongdone_rsp got st=%0d wen=%0b data=%h exp 0 0 0badc0de", o_st, o_wen, o_data);
    end
  endtask

  task automatic test_reset_in_exec();
    int ex, c;
    logic rsp_seen;
    @(negedge g_clk);
    cpi_insn_valid = 1'b1; cpi_insn = 32'h7777_0001; id_class = 9'b000000010;
    id_exception = 1'b0; gpr_write = 1'b1; id_rd = 5'd4;
    ex = 0; c = 0;
    while (ex < 3 && c < 20) begin
      @(negedge g_clk);
      cpi_insn_valid = 1'b0; c++;
      if (fu_ivalid != '0) ex++;
    end
    checks++;
    if (ex !== 3) begin errors++; $display("FAIL rstexec_reach got exec cycles=%0d exp 3", ex); end
    g_resetn = 1'b0;
    #1;
    checks++;
    if (fu_ivalid !== '0 || busy !== 1'b0 || cpi_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstexec_async got ivalid=%b busy=%0b vld=%0b exp 0", fu_ivalid, busy, cpi_rsp_valid);
    end
    repeat (2) @(negedge g_clk);
    g_resetn = 1'b1;
    rsp_seen = 1'b0;
    repeat (6) begin
      @(negedge g_clk);
      if (cpi_rsp_valid || fu_ivalid != '0) rsp_seen = 1'b1;
    end
    checks++;
    if (rsp_seen !== 1'b0) begin errors++; $display("FAIL rstexec_norsp got activity=%0b exp 0", rsp_seen); end
    drive_txn(32'h7777_0002, 9'b100000000, 1'b0, 1'b1, 5'd31, 2, '0, 32'h5555_AAAA, 0);
    checks++;
    if (o_lat !== 4 || {o_st, o_wen, o_rd, o_data} !== {3'd0, 1'b1, 5'd31, 32'h5555AAAA}) begin
      errors++; $display("FAIL rstexec_next got lat=%0d st=%0d wen=%0b rd=%0d data=%h", o_lat, o_st, o_wen, o_rd, o_data);
    end
  endtask

  task automatic test_timeout();
    drive_txn(32'h0, 9'b000010000, 1'b0, 1'b1, 5'd6, 0, 9'b000000001, 32'h0, 0);
    model(9'b000010000, 1'b0, 1'b1, 0, 32'h0);
    checks++;
    if (o_lat !== e_lat || o_ivc !== TO || o_st !== 3'd2 || o_wen !== 1'b0 || o_data !== 32'h0) begin
      errors++; $display("FAIL timeout_none got lat=%0d cyc=%0d st=%0d wen=%0b exp %0d %0d 2 0", o_lat, o_ivc, o_st, o_wen, e_lat, TO);
    end
    drive_txn(32'h1, 9'b000010000, 1'b0, 1'b1, 5'd6, TO, '0, 32'h1357_9BDF, 0);
    checks++;
    if (o_lat !== TO + 2 || o_st !== 3'd0 || o_wen !== 1'b1 || o_data !== 32'h13579BDF) begin
      errors++; $display("FAIL timeout_edge got lat=%0d st=%0d wen=%0b data=%h exp %0d 0 1 13579bdf", o_lat, o_st, o_wen, o_data, TO + 2);
    end
  endtask

  task automatic test_random();
    logic [NC-1:0] cls, wm;
    logic exc, gw;
    logic [4:0] rd;
    logic [31:0] insn, rdata;
    int lat, rdly;
    for (int i = 0; i < 40; i++) begin
      insn = $urandom; rdata = $urandom; rd = 5'($urandom);
      gw = 1'($urandom); exc = ($urandom_range(0, 99) < 15);
      cls = ($urandom_range(0, 99) < 80) ? NC'(1) << $urandom_range(0, NC - 1) : NC'($urandom);
      wm = NC'($urandom) & ~cls;
      lat = TO_EN ? $urandom_range(1, TO + 3) : $urandom_range(1, 8);
      rdly = $urandom_range(0, 3);
      drive_txn(insn, cls, exc, gw, rd, lat, wm, rdata, rdly);
      model(cls, exc, gw, lat, rdata);
      checks++;
      if (o_hung || o_lat !== e_lat || o_ivc !== e_ivc || o_ivbad) begin
        errors++; $display("FAIL rand%0d_timing got lat=%0d cyc=%0d bad=%0b exp lat=%0d cyc=%0d", i, o_lat, o_ivc, o_ivbad, e_lat, e_ivc);
      end
      checks++;
      if (o_st !== e_st || o_wen !== e_wen || o_data !== e_data || (e_st == 3'd0 && o_rd !== rd)) begin
        errors++; $display("FAIL rand%0d_rsp got st=%0d wen=%0b rd=%0d data=%h exp st=%0d wen=%0b rd=%0d data=%h",
                           i, o_st, o_wen, o_rd, o_data, e_st, e_wen, rd, e_data);
      end
      checks++;
      if (o_unstable || o_rdy_busy || o_vld_after || !o_end_rdy || !o_acc_rdy || o_enc !== insn) begin
        errors++; $display("FAIL rand%0d_proto got unstable=%0b rdybusy=%0b vldafter=%0b endrdy=%0b enc=%h exp 0 0 0 1 %h",
                           i, o_unstable, o_rdy_busy, o_vld_after, o_end_rdy, o_enc, insn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_multicycle_backpressure();
    test_decode_error();
    test_wrong_done();
    test_reset_in_exec();
    if (TO_EN) test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
